// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: opcode/funct encodings, ALU codes and the
// per-instruction control bundle carried down the pipeline.
package mips_pkg;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MOVN  = 6'b001011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_SLL  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_ADDU = 3'd5;
  localparam logic [2:0] ALU_SLT  = 3'd6;
  localparam logic [2:0] ALU_MOVN = 3'd7;

  typedef struct packed {
    logic [2:0] aluctr;
    logic       alusrc_a;
    logic       alusrc_b;
    logic       regdst;
    logic       extsign;
    logic [2:0] branch;
    logic       jump;
    logic       jr;
    logic       mem_rd;
    logic       mem_wr;
    logic       mem_size;
    logic       regwre;
    logic       dbsrc;
    logic       link;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } halt_state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational ID-stage decoder: opcode/funct to control bundle,
// plus a flag for encodings the core does not implement.
module ctrl_decode
  import mips_pkg::*;
#(
  parameter logic [5:0] HALT_OP = OP_HALT
) (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = BUBBLE;
    illegal = 1'b0;
    // Halt is checked first so it stays a legal all-zero bundle even if
    // HALT_OP is overridden onto an otherwise-decoded opcode.
    if (opcode != HALT_OP) begin
      case (opcode)
        OP_R: begin
          case (funct)
            FN_ADD:  begin ctrl.aluctr = ALU_ADD;  ctrl.regdst = 1'b1; ctrl.regwre = 1'b1; end
            FN_SUB:  begin ctrl.aluctr = ALU_SUB;  ctrl.regdst = 1'b1; ctrl.regwre = 1'b1; end
            FN_AND:  begin ctrl.aluctr = ALU_AND;  ctrl.regdst = 1'b1; ctrl.regwre = 1'b1; end
            FN_OR:   begin ctrl.aluctr = ALU_OR;   ctrl.regdst = 1'b1; ctrl.regwre = 1'b1; end
            FN_SLT:  begin ctrl.aluctr = ALU_SLT;  ctrl.regdst = 1'b1; ctrl.regwre = 1'b1; end
            FN_MOVN: begin ctrl.aluctr = ALU_MOVN; ctrl.regdst = 1'b1; ctrl.regwre = 1'b1; end
            FN_SLL: begin
              ctrl.aluctr   = ALU_SLL;
              ctrl.alusrc_a = 1'b1;
              ctrl.regdst   = 1'b1;
              ctrl.regwre   = 1'b1;
            end
            FN_JR:   ctrl.jr = 1'b1;
            default: illegal = 1'b1;
          endcase
        end
        OP_LW, OP_LHU: begin
          ctrl.aluctr   = ALU_ADD;
          ctrl.alusrc_b = 1'b1;
          ctrl.extsign  = 1'b1;
          ctrl.mem_rd   = 1'b1;
          ctrl.mem_size = (opcode == OP_LHU);
          ctrl.regwre   = 1'b1;
          ctrl.dbsrc    = 1'b1;
        end
        OP_SW: begin
          ctrl.aluctr   = ALU_ADD;
          ctrl.alusrc_b = 1'b1;
          ctrl.extsign  = 1'b1;
          ctrl.mem_wr   = 1'b1;
        end
        OP_BEQ:  begin ctrl.aluctr = ALU_SUB; ctrl.extsign = 1'b1; ctrl.branch = 3'b001; end
        OP_BNE:  begin ctrl.aluctr = ALU_SUB; ctrl.extsign = 1'b1; ctrl.branch = 3'b010; end
        OP_BLTZ: begin ctrl.aluctr = ALU_SUB; ctrl.extsign = 1'b1; ctrl.branch = 3'b100; end
        OP_ADDI, OP_ADDIU, OP_SLTI: begin
          ctrl.aluctr   = (opcode == OP_ADDI)  ? ALU_ADD :
                          (opcode == OP_ADDIU) ? ALU_ADDU : ALU_SLT;
          ctrl.alusrc_b = 1'b1;
          ctrl.extsign  = 1'b1;
          ctrl.regwre   = 1'b1;
        end
        OP_ANDI, OP_ORI: begin
          ctrl.aluctr   = (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
          ctrl.alusrc_b = 1'b1;
          ctrl.regwre   = 1'b1;
        end
        OP_J:    ctrl.jump = 1'b1;
        OP_JAL:  begin ctrl.link = 1'b1; ctrl.regwre = 1'b1; end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Pipelined MIPS control unit: decodes in ID, carries the control bundle
// through EX..WB registers, and handles bubbles, halt drain and illegal ops.
module ctrl_pipe_unit
  import mips_pkg::*;
#(
  parameter int unsigned ALUCTR_W = 3,
  parameter int unsigned STAGES   = 3,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                stall,
  input  logic                flush,
  output logic [ALUCTR_W-1:0] ex_aluctr,
  output logic                ex_alusrcA,
  output logic                ex_alusrcB,
  output logic                ex_regdst,
  output logic                ex_extsign,
  output logic [2:0]          ex_branch,
  output logic                ex_jump,
  output logic                ex_jr,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                mem_size,
  output logic                wb_regwre,
  output logic                wb_dbsrc,
  output logic                wb_link,
  output logic                pc_hold,
  output logic                halted,
  output logic                illegal
);

  localparam int unsigned CNT_W = $clog2(STAGES + 1);

  ctrl_t             dec;
  logic              dec_illegal;
  ctrl_t             stage [1:STAGES];
  halt_state_t       state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              accept;
  logic              halt_req;
  logic              illegal_seen;

  ctrl_decode #(
    .HALT_OP(HALT_OP)
  ) u_decode (
    .opcode (opcode),
    .funct  (funct),
    .ctrl   (dec),
    .illegal(dec_illegal)
  );

  // Only RUN admits instructions, so nothing younger than a halt reaches EX.
  assign accept   = id_valid & ~stall & ~flush & (state == RUN);
  assign halt_req = accept & (opcode == HALT_OP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 1; k <= STAGES; k++) stage[k] <= BUBBLE;
    end else begin
      stage[1] <= accept ? dec : BUBBLE;
      for (int unsigned k = 2; k <= STAGES; k++) stage[k] <= stage[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_seen <= 1'b0;
    end else if (accept && dec_illegal) begin
      illegal_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      RUN: begin
        if (halt_req) begin
          state_next = DRAIN;
          cnt_next   = CNT_W'(STAGES);
        end
      end
      DRAIN: begin
        if (cnt == CNT_W'(1)) state_next = HALTED;
        else                  cnt_next   = cnt - CNT_W'(1);
      end
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    pc_hold = 1'b0;
    halted  = 1'b0;
    case (state)
      DRAIN:   pc_hold = 1'b1;
      HALTED: begin
        pc_hold = 1'b1;
        halted  = 1'b1;
      end
      default: ;
    endcase
  end

  assign ex_aluctr  = ALUCTR_W'(stage[1].aluctr);
  assign ex_alusrcA = stage[1].alusrc_a;
  assign ex_alusrcB = stage[1].alusrc_b;
  assign ex_regdst  = stage[1].regdst;
  assign ex_extsign = stage[1].extsign;
  assign ex_branch  = stage[1].branch;
  assign ex_jump    = stage[1].jump;
  assign ex_jr      = stage[1].jr;
  assign mem_rd     = stage[2].mem_rd;
  assign mem_wr     = stage[2].mem_wr;
  assign mem_size   = stage[2].mem_size;
  assign wb_regwre  = stage[STAGES].regwre;
  assign wb_dbsrc   = stage[STAGES].dbsrc;
  assign wb_link    = stage[STAGES].link;
  assign illegal    = illegal_seen;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Self-checking bench for ctrl_pipe_unit: directed and random instruction
// streams against a history-queue reference, on STAGES=3 and STAGES=5 copies.
module tb_ctrl_pipe_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;

  logic [2:0] a_aluctr, a_branch, b_aluctr, b_branch;
  logic a_srca, a_srcb, a_regdst, a_ext, a_jump, a_jr, a_rd, a_wr, a_size;
  logic a_we, a_db, a_link, a_pch, a_hlt, a_ill;
  logic b_srca, b_srcb, b_regdst, b_ext, b_jump, b_jr, b_rd, b_wr, b_size;
  logic b_we, b_db, b_link, b_pch, b_hlt, b_ill;

  int total = 0;
  int bad = 0;

  // Reference state: history of what entered EX, newest first.
  logic [17:0] hist[$];
  logic        ill_m;
  bit          halting;
  int          since;

  logic [11:0] legal_tbl [21] = '{
    {6'b000000, 6'b100000}, {6'b000000, 6'b100010}, {6'b000000, 6'b100100},
    {6'b000000, 6'b100101}, {6'b000000, 6'b000000}, {6'b000000, 6'b101010},
    {6'b000000, 6'b001011}, {6'b000000, 6'b001000}, {6'b100011, 6'b010101},
    {6'b100101, 6'b000011}, {6'b101011, 6'b111111}, {6'b000100, 6'b000000},
    {6'b000101, 6'b101010}, {6'b000001, 6'b000001}, {6'b001000, 6'b110000},
    {6'b001001, 6'b000111}, {6'b001100, 6'b100000}, {6'b001101, 6'b001000},
    {6'b001010, 6'b011000}, {6'b000010, 6'b000000}, {6'b000011, 6'b111110}
  };

  always #5 clk = ~clk;

  ctrl_pipe_unit u3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode), .funct(funct),
    .stall(stall), .flush(flush),
    .ex_aluctr(a_aluctr), .ex_alusrcA(a_srca), .ex_alusrcB(a_srcb), .ex_regdst(a_regdst),
    .ex_extsign(a_ext), .ex_branch(a_branch), .ex_jump(a_jump), .ex_jr(a_jr),
    .mem_rd(a_rd), .mem_wr(a_wr), .mem_size(a_size),
    .wb_regwre(a_we), .wb_dbsrc(a_db), .wb_link(a_link),
    .pc_hold(a_pch), .halted(a_hlt), .illegal(a_ill)
  );

  ctrl_pipe_unit #(.STAGES(5)) u5 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode), .funct(funct),
    .stall(stall), .flush(flush),
    .ex_aluctr(b_aluctr), .ex_alusrcA(b_srca), .ex_alusrcB(b_srcb), .ex_regdst(b_regdst),
    .ex_extsign(b_ext), .ex_branch(b_branch), .ex_jump(b_jump), .ex_jr(b_jr),
    .mem_rd(b_rd), .mem_wr(b_wr), .mem_size(b_size),
    .wb_regwre(b_we), .wb_dbsrc(b_db), .wb_link(b_link),
    .pc_hold(b_pch), .halted(b_hlt), .illegal(b_ill)
  );

  // Expected control word straight from the instruction table:
  // {alu[2:0], srcA, srcB, regdst, ext, branch[2:0], j, jr, rd, wr, size, regwre, dbsrc, link}
  function automatic void ref_dec(input logic [5:0] op, input logic [5:0] fn,
                                  output logic [17:0] v, output logic il);
    logic [2:0] alu = 3'd0;
    logic [2:0] br = 3'd0;
    bit a = 0, b = 0, rdst = 0, ext = 0, j = 0, jr = 0;
    bit rd = 0, wr = 0, sz = 0, we = 0, db = 0, lk = 0;
    il = 1'b0;
    case (op)
      6'b000000: begin
        rdst = 1; we = 1;
        case (fn)
          6'b100000: alu = 3'd0;
          6'b100010: alu = 3'd1;
          6'b100100: alu = 3'd4;
          6'b100101: alu = 3'd3;
          6'b000000: begin alu = 3'd2; a = 1; end
          6'b101010: alu = 3'd6;
          6'b001011: alu = 3'd7;
          6'b001000: begin rdst = 0; we = 0; jr = 1; end
          default:   begin rdst = 0; we = 0; il = 1'b1; end
        endcase
      end
      6'b100011: begin b = 1; ext = 1; rd = 1; we = 1; db = 1; end
      6'b100101: begin b = 1; ext = 1; rd = 1; we = 1; db = 1; sz = 1; end
      6'b101011: begin b = 1; ext = 1; wr = 1; end
      6'b000100: begin alu = 3'd1; ext = 1; br = 3'b001; end
      6'b000101: begin alu = 3'd1; ext = 1; br = 3'b010; end
      6'b000001: begin alu = 3'd1; ext = 1; br = 3'b100; end
      6'b001000: begin b = 1; ext = 1; we = 1; end
      6'b001001: begin alu = 3'd5; b = 1; ext = 1; we = 1; end
      6'b001010: begin alu = 3'd6; b = 1; ext = 1; we = 1; end
      6'b001100: begin alu = 3'd4; b = 1; we = 1; end
      6'b001101: begin alu = 3'd3; b = 1; we = 1; end
      6'b000010: j = 1;
      6'b000011: begin lk = 1; we = 1; end
      6'b111111: ;
      default:   il = 1'b1;
    endcase
    v = {alu, a, b, rdst, ext, br, j, jr, rd, wr, sz, we, db, lk};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [17:0] h0, h1, h2, h4;
    h0 = hist[0]; h1 = hist[1]; h2 = hist[2]; h4 = hist[4];
    chk("ex3",  {a_aluctr, a_srca, a_srcb, a_regdst, a_ext, a_branch, a_jump, a_jr}, h0[17:6]);
    chk("mem3", {a_rd, a_wr, a_size}, h1[5:3]);
    chk("wb3",  {a_we, a_db, a_link}, h2[2:0]);
    chk("ex5",  {b_aluctr, b_srca, b_srcb, b_regdst, b_ext, b_branch, b_jump, b_jr}, h0[17:6]);
    chk("mem5", {b_rd, b_wr, b_size}, h1[5:3]);
    chk("wb5",  {b_we, b_db, b_link}, h4[2:0]);
    chk("pc_hold3", a_pch, halting);
    chk("pc_hold5", b_pch, halting);
    chk("halted3", a_hlt, halting && since >= 3);
    chk("halted5", b_hlt, halting && since >= 5);
    chk("illegal3", a_ill, ill_m);
    chk("illegal5", b_ill, ill_m);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0; id_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    hist.delete();
    for (int i = 0; i < 8; i++) hist.push_front('0);
    ill_m = 1'b0; halting = 0; since = 0;
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input logic v, input logic [5:0] op, input logic [5:0] fn,
                      input logic st, input logic fl);
    logic [17:0] d;
    logic        il, acc;
    id_valid = v; opcode = op; funct = fn; stall = st; flush = fl;
    ref_dec(op, fn, d, il);
    acc = v && !st && !fl && !halting;
    @(posedge clk);
    #1;
    if (halting) since++;
    if (acc && op == 6'b111111) begin halting = 1; since = 0; end
    if (acc && il) ill_m = 1'b1;
    hist.push_front(acc ? d : 18'd0);
    void'(hist.pop_back());
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 6'b000000, 6'b100000, 1'b0, 1'b0);
  endtask

  task automatic rand_steps(input int n, input int busy);
    logic [11:0] e;
    for (int i = 0; i < n; i++) begin
      e = legal_tbl[$urandom_range(0, 20)];
      step(($urandom_range(0, 3) < busy), e[11:6], e[5:0],
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    // lw latency through EX/MEM/WB
    step(1, 6'b100011, 6'b000000, 0, 0);
    idle(5);
    // add then sll back to back
    step(1, 6'b000000, 6'b100000, 0, 0);
    step(1, 6'b000000, 6'b000000, 0, 0);
    idle(5);
    // beq under stall, then without
    step(1, 6'b000100, 6'b000000, 1, 0);
    step(1, 6'b000100, 6'b000000, 0, 0);
    idle(2);
    // sw under simultaneous stall and flush, then flush alone
    step(1, 6'b101011, 6'b000000, 1, 1);
    step(1, 6'b101011, 6'b000000, 0, 1);
    idle(5);
    rand_steps(300, 3);

    // illegal encodings: rejected when stalled, sticky once accepted
    step(1, 6'b110000, 6'b000000, 1, 0);
    step(1, 6'b110000, 6'b000000, 0, 0);
    rand_steps(20, 3);
    do_reset();
    step(1, 6'b000000, 6'b111111, 0, 0);
    idle(3);
    do_reset();

    // halt: stalled halt ignored, accepted halt drains, younger work dropped
    rand_steps(20, 3);
    step(1, 6'b111111, 6'b000000, 1, 0);
    step(1, 6'b111111, 6'b000000, 0, 0);
    for (int i = 0; i < 12; i++) begin
      logic [11:0] e;
      e = legal_tbl[$urandom_range(0, 20)];
      step(1, e[11:6], e[5:0], 0, 0);
    end

    // reset in the middle of a drain returns to normal operation
    do_reset();
    rand_steps(10, 4);
    step(1, 6'b111111, 6'b000000, 0, 0);
    rand_steps(2, 4);
    do_reset();
    rand_steps(40, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_unit.md
Name: ctrl_pipe_unit

Overview:
- Next-generation MIPS control unit for the pipelined CPU.
- Decodes opcode/funct in ID and registers the control bundle into a parameterised chain of pipeline control registers (EX, MEM, optional extra stages, WB).
- Each field is presented at the stage that consumes it.
- Adds stall/flush bubble insertion, a halt-drain state machine, and sticky illegal-instruction detection.
- Every output is defined on every opcode; no latched fields.

Parameters:
- ALUCTR_W, 3, width of the ALU operation code.
- STAGES, 3, control-register stages after ID (stage 1 = EX, stage 2 = MEM, stage STAGES = WB); legal range 3..8.
- HALT_OP, 6'b111111, opcode that requests halt.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- opcode  in  6  instruction[31:26].
- funct  in  6  instruction[5:0].
- stall  in  1  hazard stall: insert a bubble into EX; later stages advance.
- flush  in  1  squash the ID instruction: insert a bubble into EX.
- ex_aluctr  out  ALUCTR_W  ALU operation.
- ex_alusrcA  out  1  A operand select: shamt when 1.
- ex_alusrcB  out  1  B operand select: immediate when 1.
- ex_regdst  out  1  destination select: rd when 1, rt when 0.
- ex_extsign  out  1  sign-extend the immediate.
- ex_branch  out  3  {lt, ne, eq} branch type.
- ex_jump  out  1  j.
- ex_jr  out  1  jr.
- mem_rd  out  1  data-memory read.
- mem_wr  out  1  data-memory write.
- mem_size  out  1  1 = halfword (lhu), 0 = word.
- wb_regwre  out  1  register write enable.
- wb_dbsrc  out  1  writeback source: memory when 1.
- wb_link  out  1  write PC+4 to $31.
- pc_hold  out  1  freeze the PC/IF stage.
- halted  out  1  pipeline drained after halt.
- illegal  out  1  sticky: unknown opcode or funct seen.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n. While rst_n=0, every output and every stage register is 0 and the FSM is in RUN.
- Decode (combinational, ID):
  - The bundle defaults to all-zero (bubble).
  - R-type (opcode 0): add→aluctr 0, sub→1, and→4, or→3, sll→2 (alusrcA=1), slt→6, movn→7. All of these set regdst=1 and regwre=1.
  - jr: jr=1 only.
  - lw/lhu: aluctr 0, alusrcB=1, extsign=1, rd=1, regwre=1, dbsrc=1; size=1 for lhu only.
  - sw: aluctr 0, alusrcB=1, extsign=1, wr=1.
  - beq/bne/bltz: aluctr 1, extsign=1, branch bit 0/1/2 respectively.
  - addi/addiu/slti: aluctr 0/5/6, alusrcB=1, extsign=1, regwre=1.
  - andi/ori: aluctr 4/3, alusrcB=1, extsign=0, regwre=1.
  - j: jump=1.
  - jal: link=1, regwre=1.
  - halt: bundle stays zero.
  - Any other opcode, or an undefined funct with opcode 0: bundle zero, raise illegal.
  - aluctr values are zero-extended into ALUCTR_W.
- Stage advance, every clock edge:
  - Stage 1 loads the decoded bundle when id_valid & ~stall & ~flush & state==RUN; otherwise it loads a bubble.
  - Stage k loads stage k-1 for k = 2..STAGES.
  - Latency from ID to an EX field is 1 cycle, to MEM is 2 cycles, to WB is STAGES cycles.
- Output mapping: EX outputs come from stage 1, MEM outputs from stage 2, WB outputs from stage STAGES.
- illegal: set on the edge at which an accepted instruction (same condition as a stage-1 load) is illegal. Cleared only by reset.
- Halt FSM:
  - RUN → DRAIN when an accepted instruction has opcode==HALT_OP. The drain counter loads STAGES.
  - DRAIN decrements the counter each cycle. At count 1 it goes to HALTED.
  - HALTED is terminal until reset.
  - pc_hold = 1 in DRAIN and in HALTED. halted = 1 only in HALTED.
  - A halt under stall or flush is not accepted.
  - Instructions younger than the halt never enter stage 1.
- Simultaneous stall and flush: a single bubble.
- Reset mid-drain: returns to RUN with all stages cleared.

Decomposition:
- Shared package mips_pkg:
  - opcode and funct constants (OP_R, OP_LW, OP_LHU, OP_SW, OP_BEQ, OP_BNE, OP_BLTZ, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_J, OP_JAL, OP_HALT, FN_*).
  - ALU code constants (ALU_ADD=0, ALU_SUB=1, ALU_SLL=2, ALU_OR=3, ALU_AND=4, ALU_ADDU=5, ALU_SLT=6, ALU_MOVN=7).
  - The control-bundle struct type and its BUBBLE constant.
- One natural sub-module: ctrl_decode, the purely combinational decoder returning the bundle and the illegal flag. The top level owns the stage registers and the FSM.

Test Plan:
- Reset then lw (opcode 100011), id_valid=1 → next cycle ex_alusrcB=1, ex_aluctr=0; +1 cycle mem_rd=1, mem_size=0; +3 cycles (STAGES=3) wb_regwre=1, wb_dbsrc=1.
- add followed by sll, back-to-back → EX shows aluctr 0 then 2 (alusrcA=1 on the second); wb_regwre=1 on both WB cycles.
- beq with stall=1 → ex_branch=000 and all outputs 0 next cycle; repeat with stall=0 → ex_branch=001.
- flush=1 and stall=1 together on sw → no mem_wr pulse at any stage.
- halt accepted at cycle T → pc_hold=1 from T+1; halted=1 at T+3 (STAGES=3) and stays high. Any instruction offered after T yields no nonzero output.
- Opcode 6'b110000 accepted → illegal=1 next cycle and persists; all stage outputs stay 0; rst_n pulse clears illegal. Rerun with STAGES=5: WB latency becomes 5 cycles.
